// File: rtl/speck_round_encrypt.sv
// rtl/speck_round_encrypt.sv - one SPECK-128/128 key-schedule step and one round, each a multi-cycle FSM
// Optional macro SPECK_STATE_RESPONSE_EN exposes the FSM encodings on the state response ports.
module speck_round_encrypt #(
  parameter int WORD  = 64,
  parameter int ALPHA = 8,
  parameter int BETA  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ks_signal_start,
  input  logic [2*WORD-1:0] key,
  input  logic [WORD-1:0]   round_ctr,
  output logic [2*WORD-1:0] out_key,
  output logic              ks_finished,
  output logic [3:0]        ks_state_response,
  input  logic              rd_signal_start,
  input  logic [WORD-1:0]   subkey,
  input  logic [2*WORD-1:0] plaintext,
  output logic [2*WORD-1:0] ciphertext,
  output logic              rd_finished,
  output logic [3:0]        rd_state_response
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LOAD = 4'd1,
    ADD  = 4'd2,
    MIX  = 4'd3,
    DONE = 4'd4
  } state_e;

  function automatic logic [WORD-1:0] ror_a(input logic [WORD-1:0] v);
    return (v >> ALPHA) | (v << (WORD - ALPHA));
  endfunction

  function automatic logic [WORD-1:0] rol_b(input logic [WORD-1:0] v);
    return (v << BETA) | (v >> (WORD - BETA));
  endfunction

  state_e            ks_state_q;
  logic [WORD-1:0]   ks_k_q, ks_l_q, ks_c_q, ks_t_q;
  logic [2*WORD-1:0] ks_out_q;
  logic              ks_fin_q;
  logic [WORD-1:0]   ks_sum_d, ks_mix_d;

  state_e            rd_state_q;
  logic [WORD-1:0]   rd_x_q, rd_y_q, rd_s_q, rd_t_q;
  logic [2*WORD-1:0] rd_out_q;
  logic              rd_fin_q;
  logic [WORD-1:0]   rd_sum_d, rd_mix_d;

  // ks_t_q / rd_t_q hold the rotate-add word after LOAD, then the first result word after ADD.
  assign ks_sum_d = ror_a(ks_l_q) + ks_k_q;
  assign ks_mix_d = rol_b(ks_k_q) ^ ks_t_q;
  assign rd_sum_d = ror_a(rd_x_q) + rd_y_q;
  assign rd_mix_d = rol_b(rd_y_q) ^ rd_t_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_state_q <= IDLE;
      ks_k_q     <= '0;
      ks_l_q     <= '0;
      ks_c_q     <= '0;
      ks_t_q     <= '0;
      ks_out_q   <= '0;
      ks_fin_q   <= 1'b0;
    end else begin
      case (ks_state_q)
        IDLE, DONE: begin
          if (ks_signal_start) begin
            ks_k_q     <= key[2*WORD-1:WORD];
            ks_l_q     <= key[WORD-1:0];
            ks_c_q     <= round_ctr;
            ks_fin_q   <= 1'b0;
            ks_state_q <= LOAD;
          end
        end
        LOAD: begin
          ks_t_q     <= ks_sum_d;
          ks_state_q <= ADD;
        end
        ADD: begin
          ks_t_q     <= ks_t_q ^ ks_c_q;
          ks_state_q <= MIX;
        end
        MIX: begin
          ks_out_q   <= {ks_mix_d, ks_t_q};
          ks_fin_q   <= 1'b1;
          ks_state_q <= DONE;
        end
        default: ks_state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= IDLE;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_s_q     <= '0;
      rd_t_q     <= '0;
      rd_out_q   <= '0;
      rd_fin_q   <= 1'b0;
    end else begin
      case (rd_state_q)
        IDLE, DONE: begin
          if (rd_signal_start) begin
            rd_x_q     <= plaintext[2*WORD-1:WORD];
            rd_y_q     <= plaintext[WORD-1:0];
            rd_s_q     <= subkey;
            rd_fin_q   <= 1'b0;
            rd_state_q <= LOAD;
          end
        end
        LOAD: begin
          rd_t_q     <= rd_sum_d;
          rd_state_q <= ADD;
        end
        ADD: begin
          rd_t_q     <= rd_t_q ^ rd_s_q;
          rd_state_q <= MIX;
        end
        MIX: begin
          rd_out_q   <= {rd_t_q, rd_mix_d};
          rd_fin_q   <= 1'b1;
          rd_state_q <= DONE;
        end
        default: rd_state_q <= IDLE;
      endcase
    end
  end

  assign out_key     = ks_out_q;
  assign ks_finished = ks_fin_q;
  assign ciphertext  = rd_out_q;
  assign rd_finished = rd_fin_q;

`ifdef SPECK_STATE_RESPONSE_EN
  assign ks_state_response = ks_state_q;
  assign rd_state_response = rd_state_q;
`else
  assign ks_state_response = 4'h0;
  assign rd_state_response = 4'h0;
`endif

endmodule

// File: tb/tb_speck_round_encrypt.sv
// tb/tb_speck_round_encrypt.sv - directed and random checks of speck_round_encrypt with a result scoreboard
module tb_speck_round_encrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         ks_signal_start;
  logic [127:0] key;
  logic [63:0]  round_ctr;
  logic [127:0] out_key;
  logic         ks_finished;
  logic [3:0]   ks_state_response;
  logic         rd_signal_start;
  logic [63:0]  subkey;
  logic [127:0] plaintext;
  logic [127:0] ciphertext;
  logic         rd_finished;
  logic [3:0]   rd_state_response;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [127:0] ks_q[$];
  logic [127:0] rd_q[$];

`ifdef SPECK_STATE_RESPONSE_EN
  localparam bit ST_EN = 1'b1;
`else
  localparam bit ST_EN = 1'b0;
`endif

  speck_round_encrypt dut (
    .clk               (clk),
    .rst               (rst),
    .ks_signal_start   (ks_signal_start),
    .key               (key),
    .round_ctr         (round_ctr),
    .out_key           (out_key),
    .ks_finished       (ks_finished),
    .ks_state_response (ks_state_response),
    .rd_signal_start   (rd_signal_start),
    .subkey            (subkey),
    .plaintext         (plaintext),
    .ciphertext        (ciphertext),
    .rd_finished       (rd_finished),
    .rd_state_response (rd_state_response)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_st(input int n);
    return ST_EN ? n[3:0] : 4'h0;
  endfunction

  function automatic logic [127:0] ks_model(input logic [127:0] kin, input logic [63:0] c);
    logic [63:0] k, l, lp, kp;
    k  = kin[127:64];
    l  = kin[63:0];
    lp = ({l[7:0], l[63:8]} + k) ^ c;
    kp = {k[60:0], k[63:61]} ^ lp;
    return {kp, lp};
  endfunction

  function automatic logic [127:0] rd_model(input logic [127:0] pt, input logic [63:0] sk);
    logic [63:0] x, y, xp, yp;
    x  = pt[127:64];
    y  = pt[63:0];
    xp = ({x[7:0], x[63:8]} + y) ^ sk;
    yp = {y[60:0], y[63:61]} ^ xp;
    return {xp, yp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic scramble();
    key       = {$urandom, $urandom, $urandom, $urandom};
    round_ctr = {$urandom, $urandom};
    subkey    = {$urandom, $urandom};
    plaintext = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Starts the selected units on the next edge; with junk set, start stays high through LOAD/ADD/MIX.
  task automatic run(input bit do_ks, input bit do_rd,
                     input logic [127:0] k, input logic [63:0] c,
                     input logic [127:0] pt, input logic [63:0] sk,
                     input logic [127:0] ks_exp, input logic [127:0] rd_exp,
                     input bit junk);
    if (do_ks) ks_q.push_back(ks_exp);
    if (do_rd) rd_q.push_back(rd_exp);
    key = k; round_ctr = c; plaintext = pt; subkey = sk;
    ks_signal_start = do_ks;
    rd_signal_start = do_rd;
    for (int n = 0; n <= 3; n++) begin
      tick();
      scramble();
      if (!(junk && n < 3)) begin
        ks_signal_start = 1'b0;
        rd_signal_start = 1'b0;
      end
      if (do_ks) begin
        chk($sformatf("ks_finished_e%0d", n), {127'd0, ks_finished}, {127'd0, n == 3});
        chk($sformatf("ks_state_e%0d", n), {124'd0, ks_state_response}, {124'd0, exp_st(n + 1)});
      end
      if (do_rd) begin
        chk($sformatf("rd_finished_e%0d", n), {127'd0, rd_finished}, {127'd0, n == 3});
        chk($sformatf("rd_state_e%0d", n), {124'd0, rd_state_response}, {124'd0, exp_st(n + 1)});
      end
    end
    if (do_ks) begin
      if (ks_q.size() == 0) chk("ks_scoreboard_empty", 128'd1, 128'd0);
      else chk("out_key", out_key, ks_q.pop_front());
    end
    if (do_rd) begin
      if (rd_q.size() == 0) chk("rd_scoreboard_empty", 128'd1, 128'd0);
      else chk("ciphertext", ciphertext, rd_q.pop_front());
    end
  endtask

  initial begin
    logic [127:0] rk, rp;
    logic [63:0]  rc, rs;
    bit           rj;

    rst = 1'b1;
    ks_signal_start = 1'b0;
    rd_signal_start = 1'b0;
    key = '0; round_ctr = '0; subkey = '0; plaintext = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_out_key", out_key, 128'd0);
    chk("reset_ciphertext", ciphertext, 128'd0);
    chk("reset_ks_finished", {127'd0, ks_finished}, 128'd0);
    chk("reset_rd_finished", {127'd0, rd_finished}, 128'd0);
    chk("reset_ks_state", {124'd0, ks_state_response}, 128'd0);
    chk("reset_rd_state", {124'd0, rd_state_response}, 128'd0);

    run(1, 0, 128'd0, 64'd1, 128'd0, 64'd0, {64'h1, 64'h1}, 128'd0, 0);
    chk("rd_idle_during_ks", {127'd0, rd_finished}, 128'd0);
    run(1, 0, {64'h1, 64'h0}, 64'd0, 128'd0, 64'd0, {64'h9, 64'h1}, 128'd0, 0);
    run(0, 1, 128'd0, 64'd0, {64'h0, 64'h1}, 64'd0, 128'd0, {64'h1, 64'h9}, 0);
    run(0, 1, 128'd0, 64'd0, {64'h00000000000000FF, 64'h0100000000000000}, 64'd0,
        128'd0, {64'h0, 64'h0800000000000000}, 0);

    tick();
    tick();
    chk("hold_out_key", out_key, {64'h9, 64'h1});
    chk("hold_ciphertext", ciphertext, {64'h0, 64'h0800000000000000});
    chk("hold_ks_finished", {127'd0, ks_finished}, 128'd1);
    chk("hold_rd_finished", {127'd0, rd_finished}, 128'd1);

    run(1, 1, 128'd0, 64'd1, {64'h0, 64'h1}, 64'd0, {64'h1, 64'h1}, {64'h1, 64'h9}, 1);
    run(0, 1, 128'd0, 64'd0, 128'd0, 64'd1, 128'd0, {64'h1, 64'h1}, 1);
    chk("ks_untouched_out_key", out_key, {64'h1, 64'h1});
    chk("ks_untouched_finished", {127'd0, ks_finished}, 128'd1);

    for (int i = 0; i < 4; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      rc = {$urandom, $urandom};
      rs = {$urandom, $urandom};
      rj = 1'($urandom_range(0, 1));
      run(1, 1, rk, rc, rp, rs, ks_model(rk, rc), rd_model(rp, rs), rj);
    end

    key = {64'h1, 64'h0}; round_ctr = 64'd0;
    plaintext = {64'h0, 64'h1}; subkey = 64'd0;
    ks_signal_start = 1'b1;
    rd_signal_start = 1'b1;
    tick();
    ks_signal_start = 1'b0;
    rd_signal_start = 1'b0;
    tick();
    chk("pre_reset_ks_state", {124'd0, ks_state_response}, {124'd0, exp_st(2)});
    chk("pre_reset_rd_state", {124'd0, rd_state_response}, {124'd0, exp_st(2)});
    #2 rst = 1'b1;
    #1;
    chk("async_reset_out_key", out_key, 128'd0);
    chk("async_reset_ciphertext", ciphertext, 128'd0);
    chk("async_reset_ks_finished", {127'd0, ks_finished}, 128'd0);
    chk("async_reset_rd_finished", {127'd0, rd_finished}, 128'd0);
    chk("async_reset_ks_state", {124'd0, ks_state_response}, 128'd0);
    chk("async_reset_rd_state", {124'd0, rd_state_response}, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(1, 1, {64'h1, 64'h0}, 64'd0, {64'h0, 64'h1}, 64'd0, {64'h9, 64'h1}, {64'h1, 64'h9}, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
